// File: rtl/frame_buffer_writer_pkg.sv
// Shared constants and encodings for the frame buffer write engine.
// Register offsets, command ops and FSM states used by the top and the bench.
package frame_buffer_writer_pkg;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam logic [7:0] BASE_ADDR_DEF = 8'hB0;

  localparam logic [2:0] OFF_X0     = 3'd0;
  localparam logic [2:0] OFF_Y0     = 3'd1;
  localparam logic [2:0] OFF_W      = 3'd2;
  localparam logic [2:0] OFF_H      = 3'd3;
  localparam logic [2:0] OFF_CMD    = 3'd4;
  localparam logic [2:0] OFF_COL_LO = 3'd5;
  localparam logic [2:0] OFF_COL_HI = 3'd6;

  typedef enum logic [1:0] {
    OP_PLOT  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_RECT  = 2'b10,
    OP_NOP   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLOT = 2'd1,
    ST_FILL = 2'd2
  } state_e;

endpackage

// File: rtl/fb_scan_counter.sv
// Loadable 2-D pixel scanner: walks X fastest across an extent, then steps Y.
// Coordinates are kept 9 bits wide so rectangles never wrap past 255.
module fb_scan_counter
  import frame_buffer_writer_pkg::*;
#(
  parameter int FB_W = FB_WIDTH,
  parameter int FB_H = FB_HEIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [8:0] x_start,
  input  logic [8:0] y_start,
  input  logic [7:0] width,
  input  logic [7:0] height,
  output logic [7:0] cur_x,
  output logic [6:0] cur_y,
  output logic       last,
  output logic       in_bounds
);

  logic [8:0] x_q, x_d, y_q, y_d, x0_q, x0_d;
  logic [7:0] col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    x0_d  = x0_q;
    col_d = col_q;
    row_d = row_q;
    w_d   = w_q;
    h_d   = h_q;
    if (load) begin
      x_d   = x_start;
      y_d   = y_start;
      x0_d  = x_start;
      col_d = 8'd0;
      row_d = 8'd0;
      w_d   = width;
      h_d   = height;
    end else if (step) begin
      if (col_q == w_q - 8'd1) begin
        col_d = 8'd0;
        x_d   = x0_q;
        row_d = row_q + 8'd1;
        y_d   = y_q + 9'd1;
      end else begin
        col_d = col_q + 8'd1;
        x_d   = x_q + 9'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      x0_q  <= '0;
      col_q <= '0;
      row_q <= '0;
      w_q   <= '0;
      h_q   <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      x0_q  <= x0_d;
      col_q <= col_d;
      row_q <= row_d;
      w_q   <= w_d;
      h_q   <= h_d;
    end
  end

  assign cur_x     = x_q[7:0];
  assign cur_y     = y_q[6:0];
  assign last      = (col_q == w_q - 8'd1) && (row_q == h_q - 8'd1);
  assign in_bounds = (x_q < 9'(FB_W)) && (y_q < 9'(FB_H));

endmodule

// File: rtl/frame_buffer_writer.sv
// Bus-mapped plot/clear/rect engine driving the frame buffer RAM write port,
// plus the colour register for the VGA generator.
module frame_buffer_writer
  import frame_buffer_writer_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int         FB_W      = FB_WIDTH,
  parameter int         FB_H      = FB_HEIGHT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  input  logic [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  output logic        BUSY,
  output logic [14:0] FB_ADDR,
  output logic        FB_DATA,
  output logic        FB_WE,
  output logic [15:0] CONFIG_COLOURS
);

  state_e      state_q, state_d;
  logic [7:0]  x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic        pix_q, pix_d, zero_q, zero_d;
  logic [15:0] colour_q, colour_d;

  logic [7:0] off_full;
  logic       accept;
  logic       ld, step;
  logic [8:0] ld_x, ld_y;
  logic [7:0] ld_w, ld_h;
  logic [7:0] cur_x;
  logic [6:0] cur_y;
  logic       last, in_bounds;

  // Offset compare via subtraction also rejects addresses below the base.
  assign off_full = BUS_ADDR - BASE_ADDR;
  assign accept   = BUS_WE && (off_full <= 8'd6) && (state_q == ST_IDLE);

  always_comb begin
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    pix_d    = pix_q;
    colour_d = colour_q;
    if (accept) begin
      case (off_full[2:0])
        OFF_X0:     x0_d = BUS_DATA;
        OFF_Y0:     y0_d = BUS_DATA;
        OFF_W:      w_d  = BUS_DATA;
        OFF_H:      h_d  = BUS_DATA;
        OFF_CMD:    pix_d = BUS_DATA[0];
        OFF_COL_LO: colour_d[7:0]  = BUS_DATA;
        OFF_COL_HI: colour_d[15:8] = BUS_DATA;
        default:    ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    zero_d  = zero_q;
    ld      = 1'b0;
    step    = 1'b0;
    ld_x    = {1'b0, x0_q};
    ld_y    = {1'b0, y0_q};
    ld_w    = w_q;
    ld_h    = h_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && off_full[2:0] == OFF_CMD) begin
          case (op_e'(BUS_DATA[2:1]))
            OP_PLOT: begin
              ld      = 1'b1;
              ld_w    = 8'd1;
              ld_h    = 8'd1;
              zero_d  = 1'b0;
              state_d = ST_PLOT;
            end
            OP_CLEAR: begin
              ld      = 1'b1;
              ld_x    = 9'd0;
              ld_y    = 9'd0;
              ld_w    = 8'(FB_W);
              ld_h    = 8'(FB_H);
              zero_d  = 1'b0;
              state_d = ST_FILL;
            end
            OP_RECT: begin
              ld      = 1'b1;
              zero_d  = (w_q == 8'd0) || (h_q == 8'd0);
              state_d = ST_FILL;
            end
            default: ;
          endcase
        end
      end
      ST_PLOT: state_d = ST_IDLE;
      ST_FILL: begin
        if (zero_q || last) state_d = ST_IDLE;
        else                step = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      pix_q    <= 1'b0;
      zero_q   <= 1'b0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      pix_q    <= pix_d;
      zero_q   <= zero_d;
      colour_q <= colour_d;
    end
  end

  fb_scan_counter #(.FB_W(FB_W), .FB_H(FB_H)) u_scan (
    .clk       (CLK),
    .rst       (RESET),
    .load      (ld),
    .step      (step),
    .x_start   (ld_x),
    .y_start   (ld_y),
    .width     (ld_w),
    .height    (ld_h),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .last      (last),
    .in_bounds (in_bounds)
  );

  // Outputs are straight decodes of flops, so they change only on the clock edge.
  assign BUSY           = (state_q != ST_IDLE);
  assign FB_WE          = BUSY && !zero_q && in_bounds;
  assign FB_ADDR        = {cur_y, cur_x};
  assign FB_DATA        = pix_q;
  assign CONFIG_COLOURS = colour_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: vector table plus multi-cycle sequences.
module tb_frame_buffer_writer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BUS_ADDR, BUS_DATA;
  logic        BUS_WE;
  logic        BUSY, FB_DATA, FB_WE;
  logic [14:0] FB_ADDR;
  logic [15:0] CONFIG_COLOURS;

  int n_cmp = 0;
  int n_err = 0;

  frame_buffer_writer dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUS_WE(BUS_WE), .BUSY(BUSY), .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA),
    .FB_WE(FB_WE), .CONFIG_COLOURS(CONFIG_COLOURS)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic        busy;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic        fb_data;
    logic [15:0] col;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller sits on a falling edge; returns on the falling edge of cycle n+1.
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    BUS_ADDR = a; BUS_DATA = d; BUS_WE = 1'b1;
    @(negedge CLK);
    BUS_WE = 1'b0;
  endtask

  function automatic vec_t mk(input logic we, input logic [7:0] a, input logic [7:0] d,
                              input logic b, input logic fw, input logic [14:0] fa,
                              input logic fd, input logic [15:0] c);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.busy = b; v.fb_we = fw;
    v.fb_addr = fa; v.fb_data = fd; v.col = c;
    return v;
  endfunction

  int busy_cnt, wr_cnt, bad_data, gaps;
  logic [14:0] first_a, last_a;
  logic [14:0] rect_a[$];
  logic [14:0] exp_rect[4];
  bit seen;

  initial begin
    RESET = 1'b1; BUS_ADDR = '0; BUS_DATA = '0; BUS_WE = 1'b0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;

    // ---------------- vector table ----------------
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 15'h0000, 0, 16'h0000)); // reset state
    vecs.push_back(mk(1, 8'hB0, 8'h03, 0, 0, 15'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 8'hB1, 8'h02, 0, 0, 15'h0000, 0, 16'h0000));
    vecs.push_back(mk(1, 8'hB4, 8'h01, 1, 1, 15'h0203, 1, 16'h0000)); // PLOT (3,2)
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 15'h0000, 1, 16'h0000));
    vecs.push_back(mk(1, 8'hB5, 8'h3C, 0, 0, 15'h0000, 1, 16'h003C));
    vecs.push_back(mk(1, 8'hB6, 8'h12, 0, 0, 15'h0000, 1, 16'h123C));
    vecs.push_back(mk(1, 8'hB7, 8'h55, 0, 0, 15'h0000, 1, 16'h123C)); // out of range
    vecs.push_back(mk(1, 8'hAF, 8'h55, 0, 0, 15'h0000, 1, 16'h123C)); // below base
    vecs.push_back(mk(1, 8'hB4, 8'h07, 0, 0, 15'h0000, 1, 16'h123C)); // op 11
    vecs.push_back(mk(1, 8'hB0, 8'h0A, 0, 0, 15'h0000, 1, 16'h123C));
    vecs.push_back(mk(1, 8'hB1, 8'h04, 0, 0, 15'h0000, 1, 16'h123C));
    vecs.push_back(mk(1, 8'hB2, 8'h02, 0, 0, 15'h0000, 1, 16'h123C));
    vecs.push_back(mk(1, 8'hB3, 8'h01, 0, 0, 15'h0000, 1, 16'h123C));
    vecs.push_back(mk(1, 8'hB4, 8'h04, 1, 1, 15'h040A, 0, 16'h123C)); // RECT 2x1
    vecs.push_back(mk(1, 8'hB5, 8'hFF, 1, 1, 15'h040B, 0, 16'h123C)); // locked out
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 15'h0000, 0, 16'h123C));
    vecs.push_back(mk(1, 8'hB2, 8'h00, 0, 0, 15'h0000, 0, 16'h123C));
    vecs.push_back(mk(1, 8'hB4, 8'h05, 1, 0, 15'h0000, 1, 16'h123C)); // W=0
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 15'h0000, 1, 16'h123C));

    foreach (vecs[i]) begin
      BUS_WE = vecs[i].we; BUS_ADDR = vecs[i].addr; BUS_DATA = vecs[i].data;
      @(negedge CLK);
      BUS_WE = 1'b0;
      chk($sformatf("vec%0d busy", i), BUSY, vecs[i].busy);
      chk($sformatf("vec%0d fb_we", i), FB_WE, vecs[i].fb_we);
      chk($sformatf("vec%0d fb_data", i), FB_DATA, vecs[i].fb_data);
      chk($sformatf("vec%0d colours", i), CONFIG_COLOURS, vecs[i].col);
      if (vecs[i].fb_we) chk($sformatf("vec%0d fb_addr", i), FB_ADDR, vecs[i].fb_addr);
    end

    // ---------------- clipped RECT ----------------
    wr(8'hB0, 8'd158); wr(8'hB1, 8'd118); wr(8'hB2, 8'd4); wr(8'hB3, 8'd3);
    wr(8'hB4, 8'h05);
    exp_rect[0] = {7'd118, 8'd158}; exp_rect[1] = {7'd118, 8'd159};
    exp_rect[2] = {7'd119, 8'd158}; exp_rect[3] = {7'd119, 8'd159};
    busy_cnt = 0; bad_data = 0;
    for (int c = 0; c < 40 && (BUSY || c == 0); c++) begin
      if (BUSY) busy_cnt++;
      if (FB_WE) begin
        rect_a.push_back(FB_ADDR);
        if (FB_DATA !== 1'b1) bad_data++;
      end
      @(negedge CLK);
    end
    chk("rect busy cycles", busy_cnt, 12);
    chk("rect write count", rect_a.size(), 4);
    chk("rect data errs", bad_data, 0);
    for (int k = 0; k < 4; k++)
      chk($sformatf("rect addr%0d", k), (k < rect_a.size()) ? int'(rect_a[k]) : -1,
          int'(exp_rect[k]));

    // ---------------- CLEAR with lockout ----------------
    wr(8'hB4, 8'h02);
    busy_cnt = 0; wr_cnt = 0; bad_data = 0; gaps = 0; first_a = '1; last_a = '0;
    seen = 0;
    for (int c = 0; c < 20100 && BUSY; c++) begin
      BUS_WE = 1'b0;
      busy_cnt++;
      if (FB_WE) begin
        if (!seen) first_a = FB_ADDR;
        seen = 1;
        last_a = FB_ADDR;
        wr_cnt++;
        if (FB_DATA !== 1'b0) bad_data++;
      end else gaps++;
      if (busy_cnt == 100) begin
        BUS_ADDR = 8'hB0; BUS_DATA = 8'd77; BUS_WE = 1'b1;
      end
      if (FB_ADDR == {7'd119, 8'd159}) begin
        BUS_ADDR = 8'hB5; BUS_DATA = 8'h99; BUS_WE = 1'b1; // last busy cycle
      end
      @(negedge CLK);
    end
    BUS_WE = 1'b0;
    chk("clear busy cycles", busy_cnt, 19200);
    chk("clear write count", wr_cnt, 19200);
    chk("clear gaps", gaps, 0);
    chk("clear data errs", bad_data, 0);
    chk("clear first addr", first_a, 15'h0000);
    chk("clear last addr", last_a, {7'd119, 8'd159});
    chk("clear busy low", BUSY, 0);
    chk("colour after edge write", CONFIG_COLOURS, 16'h123C);

    @(negedge CLK);
    wr(8'hB5, 8'hAA); wr(8'hB6, 8'h00);
    chk("colours after busy", CONFIG_COLOURS, 16'h00AA);

    // X0 must still be 158: the write during CLEAR was dropped
    wr(8'hB1, 8'd0); wr(8'hB4, 8'h01);
    chk("x0 lockout plot we", FB_WE, 1);
    chk("x0 lockout plot addr", FB_ADDR, {7'd0, 8'd158});
    @(negedge CLK);

    // ---------------- reset mid-CLEAR ----------------
    wr(8'hB4, 8'h02);
    repeat (49) @(negedge CLK);
    chk("mid clear busy", BUSY, 1);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    chk("reset fb_we", FB_WE, 0);
    chk("reset busy", BUSY, 0);
    chk("reset colours", CONFIG_COLOURS, 16'h0000);
    wr_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (FB_WE) wr_cnt++;
      if (BUSY) busy_cnt++;
      @(negedge CLK);
    end
    chk("post reset writes", wr_cnt, 0);
    chk("post reset busy", busy_cnt, 0);
    wr(8'hB0, 8'd5); wr(8'hB1, 8'd5); wr(8'hB4, 8'h01);
    chk("replot we", FB_WE, 1);
    chk("replot addr", FB_ADDR, 15'h0505);
    chk("replot data", FB_DATA, 1);
    chk("replot busy", BUSY, 1);
    @(negedge CLK);
    chk("replot done", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
